uart_tx_fifo: RTL

Byte FIFO and launch sequencer sitting directly upstream of the UART transmitter. It accepts bytes from the host at any rate up to one per clock and buffers them. It then hands them one at a time to the transmitter through its start strobe and byte bus, and waits for the transmitter's done pulse before launching the next byte. This lets software queue a message without polling transmitter status.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg : shared UART data width and launch-sequencer state type ====
// ==== rev 1.0 ==============================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } tx_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ==== sync_fifo : power-of-two byte FIFO with count and sticky overflow ====
// ==== rev 1.0 ==============================================================
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = UART_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              overflow_q;
  logic              do_pop;
  logic              wr_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still takes the write.
  assign do_pop = pop_i && !empty_o;
  assign wr_ok  = wr_en_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      if (wr_en_i && !wr_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ==== uart_tx_fifo : byte queue that launches one byte at a time into the UART transmitter ====
// ==== rev 1.0 ================================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_overflow,
  output logic                   o_tx_start,
  output logic [UART_DATA_W-1:0] o_tx_byte,
  input  logic                   i_tx_done,
  output logic                   o_busy
);

  tx_seq_state_t          state_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_byte_q;
  logic [UART_DATA_W-1:0] head_byte;
  logic                   fifo_empty;
  logic                   pop;

  assign pop = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (i_rst_n),
    .wr_en_i    (i_wr_en),
    .wr_data_i  (i_wr_data),
    .pop_i      (pop),
    .rd_data_o  (head_byte),
    .full_o     (o_full),
    .empty_o    (fifo_empty),
    .count_o    (o_count),
    .overflow_o (o_overflow)
  );

  // GAP gives the transmitter one cycle to fall back to idle before the next strobe.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            tx_byte_q  <= head_byte;
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: state_q <= BUSY;
        BUSY: begin
          if (i_tx_done) begin
            state_q <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_empty    = fifo_empty;
  assign o_tx_start = tx_start_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_busy     = (state_q != IDLE);

endmodule
`default_nettype wire
